ip1_test_sequencer: RTL and testbench
=====================================

# ip1_test_sequencer

Runs a programmed list of ip1 test state machines back-to-back. For each selected test it enables the FSM, issues a one-cycle start pulse and waits for that test's done flag, with an optional watchdog. A registered output multiplexer gives exactly one test ownership of the shared DUT pads: config clock, reset_not, config/scan inputs and loads, and trigger. The block sits between the AXI register bank and the per-test FSMs (test1..testN).

## Interface
- N_TESTS, default 4: number of test FSMs attached (2..15)
- TMO_W, default 24: watchdog counter width
- clk  in  1  FM clock, 100 MHz (S_AXI_ACLK)
- reset  in  1  asynchronous, active-high
- seq_start  in  1  level from register; rising edge launches a sequence
- seq_abort  in  1  level; stops the sequence while high
- seq_test_mask  in  N_TESTS  bit i set = run test i; sampled at launch
- seq_timeout_max  in  TMO_W  per-test watchdog limit in clk cycles; 0 = disabled
- test_status_done  in  N_TESTS  per-test done flag (sticky until the next start)
- test_pads  in  7*N_TESTS  per test, bits [7i+6:7i]: scan_load, scan_in, vin_test_trig_out, config_load, config_in, reset_not, config_clk
- test_enable  out  N_TESTS  one-hot or zero; the owning test's enable
- test_start_re  out  N_TESTS  one-cycle start pulse to the owning test
- pad_config_clk, pad_reset_not, pad_config_in, pad_config_load, pad_vin_test_trig_out, pad_scan_in, pad_scan_load  out  1 each  muxed, registered pads
- seq_state  out  3  current FSM state
- seq_cur_test  out  4  index of the owning test
- seq_busy, seq_done, seq_aborted, seq_timeout_err  out  1 each  status
- seq_fail_mask  out  N_TESTS  tests that timed out

## Operation
- States: IDLE=0, SELECT=1, START=2, WAIT_DONE=3, NEXT=4, DONE=5.
- IDLE:
  - A registered rising edge of seq_start latches seq_test_mask into pending, clears done, aborted, timeout_err and fail_mask, then enters SELECT.
  - A seq_start that is already high at reset release is not an edge.
- SELECT:
  - Picks the lowest set bit of pending, loads seq_cur_test and goes to START.
  - If pending is 0, goes to DONE. An empty mask completes immediately with nothing run.
- START:
  - Asserts test_enable[cur], pulses test_start_re[cur] for exactly one cycle, clears the watchdog and goes to WAIT_DONE.
- WAIT_DONE:
  - test_enable[cur] stays high.
  - Completion is a rising edge of test_status_done[cur] (the previous value is registered). A stale high done flag from an earlier run is ignored.
  - On completion, goes to NEXT.
  - If the watchdog reaches seq_timeout_max (non-zero), sets fail_mask[cur] and seq_timeout_err, then goes to NEXT.
- NEXT: clears pending[cur], drops test_enable, goes to SELECT.
- DONE: seq_done=1, seq_busy=0. Returns to IDLE on the next seq_start rising edge, which is treated as a new launch.
- seq_busy=1 in SELECT through NEXT.
- seq_abort high in any non-IDLE, non-DONE state:
  - test_enable goes to 0, which forces the test FSM to its idle state.
  - seq_aborted=1, then DONE on the next cycle.
  - Abort takes priority over completion and timeout in the same cycle.
- Pad mux:
  - When test_enable is zero, pads take safe defaults: config_clk 0, reset_not 1, config_in 0, config_load 1 (parallel-out), others 0.
  - Otherwise the pads take the owning test's slice of test_pads.

## Timing
- Reset (asynchronous): state IDLE, all status outputs 0, test_enable 0, test_start_re 0, seq_cur_test 0, pads at safe defaults.
- Reset mid-sequence takes effect immediately; pending is lost.
- seq_start edge to test_start_re pulse: 3 clk (edge register, SELECT, START).
- Pads follow test_pads with 1 clk latency; the mux select changes in the same cycle as test_enable.
- Done rising edge to next test's start pulse: 4 clk (edge detect, NEXT, SELECT, START).
- Watchdog counts clk cycles in WAIT_DONE, saturates at all-ones and does not wrap.
- A timeout fires when count == seq_timeout_max.

## Configuration
- IP1_TEST_SEQ_TIMEOUT_EN defined: watchdog is present as described.
- Not defined: no counter logic. seq_timeout_max is ignored, seq_timeout_err and seq_fail_mask are tied 0, and WAIT_DONE exits only on done or abort.

## Structure
- Package ip1_test_seq_pkg holds:
  - the state enum (3-bit);
  - pad bit-index localparams (0..6);
  - the 7-bit safe-default pad vector;
  - the PAD_W=7 constant.
- Sub-module ip1_test_seq_pad_mux: registered N-to-1 pad mux with the safe default when the enable vector is zero, asynchronous reset to the default.

## Test plan
- Mask 4'b0101, each test raises done 50 cycles after its start pulse:
  - start pulses on test0 then test2, none on test1 or test3;
  - seq_done=1 with fail_mask 0;
  - pads mirror test0, then test2, then return to defaults.
- Mask 4'b0000: seq_done=1 three cycles after the seq_start edge, no test_start_re pulses.
- test_status_done[1] already high before the run, mask 4'b0010: the stale level is ignored and the sequence completes only on a fresh 0->1 edge.
- seq_timeout_max=100, test3 never completes, mask 4'b1000:
  - seq_timeout_err=1 and fail_mask=4'b1000 after 100 WAIT_DONE cycles;
  - with the macro undefined, the sequence stays in WAIT_DONE indefinitely.
- seq_abort raised mid-WAIT_DONE on test1 (timeout on, done asserted the same cycle): test_enable goes to 0, seq_aborted=1, DONE next cycle, remaining tests skipped.
- reset pulsed mid-sequence: all outputs return to their reset values asynchronously, and a new seq_start edge runs the full mask again.

Source files
------------

// File: rtl/ip1_test_seq_pkg.sv
// Shared types and constants for the ip1 test sequencer: FSM state encoding
// and the layout / safe-default value of the per-test pad slice.
package ip1_test_seq_pkg;

    localparam int PAD_W = 7;

    localparam int PAD_CONFIG_CLK  = 0;
    localparam int PAD_RESET_NOT   = 1;
    localparam int PAD_CONFIG_IN   = 2;
    localparam int PAD_CONFIG_LOAD = 3;
    localparam int PAD_VIN_TRIG    = 4;
    localparam int PAD_SCAN_IN     = 5;
    localparam int PAD_SCAN_LOAD   = 6;

    // reset_not released and config_load in parallel-out; everything else low
    localparam logic [PAD_W-1:0] PAD_SAFE_DEFAULT = 7'b000_1010;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/ip1_test_seq_pad_mux.sv
// Registered N-to-1 pad multiplexer. The enable vector is one-hot or zero;
// zero selects the safe default pad levels, which are also the reset value.
module ip1_test_seq_pad_mux
    import ip1_test_seq_pkg::*;
#(
    parameter int N_TESTS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_TESTS-1:0]         sel_en,
    input  logic [PAD_W*N_TESTS-1:0]   test_pads,
    output logic [PAD_W-1:0]           pads_q
);

    logic [PAD_W-1:0] pads_nxt;

    always_comb begin
        pads_nxt = '0;
        for (int i = 0; i < N_TESTS; i++) begin
            if (sel_en[i]) begin
                pads_nxt = pads_nxt | test_pads[PAD_W*i +: PAD_W];
            end
        end
        if (sel_en == '0) begin
            pads_nxt = PAD_SAFE_DEFAULT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pads_q <= PAD_SAFE_DEFAULT;
        end else begin
            pads_q <= pads_nxt;
        end
    end

endmodule

// File: rtl/ip1_test_sequencer.sv
// Runs the masked ip1 test FSMs back-to-back and owns the shared pads.
// Optional watchdog: define IP1_TEST_SEQ_TIMEOUT_EN.
module ip1_test_sequencer
    import ip1_test_seq_pkg::*;
#(
    parameter int N_TESTS = 4,
    parameter int TMO_W   = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seq_start,
    input  logic                       seq_abort,
    input  logic [N_TESTS-1:0]         seq_test_mask,
    input  logic [TMO_W-1:0]           seq_timeout_max,
    input  logic [N_TESTS-1:0]         test_status_done,
    input  logic [PAD_W*N_TESTS-1:0]   test_pads,
    output logic [N_TESTS-1:0]         test_enable,
    output logic [N_TESTS-1:0]         test_start_re,
    output logic                       pad_config_clk,
    output logic                       pad_reset_not,
    output logic                       pad_config_in,
    output logic                       pad_config_load,
    output logic                       pad_vin_test_trig_out,
    output logic                       pad_scan_in,
    output logic                       pad_scan_load,
    output logic [2:0]                 seq_state,
    output logic [3:0]                 seq_cur_test,
    output logic                       seq_busy,
    output logic                       seq_done,
    output logic                       seq_aborted,
    output logic                       seq_timeout_err,
    output logic [N_TESTS-1:0]         seq_fail_mask
);

    // Test handshake: the owning test sees test_enable held high from START
    // until NEXT, a single-cycle test_start_re in START, and reports completion
    // by a 0->1 transition of its sticky done flag; a level alone never counts.

    seq_state_e         state, state_nxt;
    logic [N_TESTS-1:0] pending, pending_nxt;
    logic [3:0]         cur, cur_nxt, sel_idx;
    logic [N_TESTS-1:0] cur_oh;
    logic               start_q, start_edge_r;
    logic [N_TESTS-1:0] done_q, done_edge_r;
    logic               aborted_nxt, tmo_err_nxt;
    logic [N_TESTS-1:0] fail_nxt;
    logic               cur_done;
    logic [PAD_W-1:0]   pads_q;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]   wdog, wdog_nxt;
`else
    logic               unused_tmo;
    assign unused_tmo = ^seq_timeout_max;
`endif

    assign cur_oh   = {{(N_TESTS-1){1'b0}}, 1'b1} << cur;
    assign cur_done = |(done_edge_r & cur_oh);

    always_comb begin
        sel_idx = '0;
        for (int i = N_TESTS-1; i >= 0; i--) begin
            if (pending[i]) sel_idx = 4'(i);
        end
    end

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        cur_nxt       = cur;
        aborted_nxt   = seq_aborted;
        tmo_err_nxt   = seq_timeout_err;
        fail_nxt      = seq_fail_mask;
        test_enable   = '0;
        test_start_re = '0;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
        wdog_nxt      = wdog;
`endif
        case (state)
            // A launch from DONE behaves exactly like one from IDLE
            S_IDLE, S_DONE: begin
                if (start_edge_r) begin
                    pending_nxt = seq_test_mask;
                    aborted_nxt = 1'b0;
                    tmo_err_nxt = 1'b0;
                    fail_nxt    = '0;
                    state_nxt   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pending == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cur_nxt   = sel_idx;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                test_enable   = cur_oh;
                test_start_re = cur_oh;
                state_nxt     = S_WAIT_DONE;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
                wdog_nxt      = '0;
`endif
            end
            S_WAIT_DONE: begin
                test_enable = cur_oh;
                if (cur_done) begin
                    state_nxt = S_NEXT;
                end
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
                else if (seq_timeout_max != '0 && wdog == seq_timeout_max) begin
                    fail_nxt    = seq_fail_mask | cur_oh;
                    tmo_err_nxt = 1'b1;
                    state_nxt   = S_NEXT;
                end else if (wdog != {TMO_W{1'b1}}) begin
                    wdog_nxt = wdog + TMO_W'(1);
                end
`endif
            end
            S_NEXT: begin
                pending_nxt = pending & ~cur_oh;
                state_nxt   = S_SELECT;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort wins over completion and timeout evaluated above
        if (seq_abort && state != S_IDLE && state != S_DONE) begin
            test_enable   = '0;
            test_start_re = '0;
            pending_nxt   = pending;
            cur_nxt       = cur;
            tmo_err_nxt   = seq_timeout_err;
            fail_nxt      = seq_fail_mask;
            aborted_nxt   = 1'b1;
            state_nxt     = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            pending         <= '0;
            cur             <= '0;
            start_q         <= 1'b1;  // a level already high at release is no edge
            start_edge_r    <= 1'b0;
            done_q          <= '0;
            done_edge_r     <= '0;
            seq_aborted     <= 1'b0;
            seq_timeout_err <= 1'b0;
            seq_fail_mask   <= '0;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
            wdog            <= '0;
`endif
        end else begin
            state           <= state_nxt;
            pending         <= pending_nxt;
            cur             <= cur_nxt;
            start_q         <= seq_start;
            start_edge_r    <= seq_start & ~start_q;
            done_q          <= test_status_done;
            done_edge_r     <= test_status_done & ~done_q;
            seq_aborted     <= aborted_nxt;
            seq_timeout_err <= tmo_err_nxt;
            seq_fail_mask   <= fail_nxt;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
            wdog            <= wdog_nxt;
`endif
        end
    end

    ip1_test_seq_pad_mux #(.N_TESTS(N_TESTS)) u_pad_mux (
        .clk       (clk),
        .reset     (reset),
        .sel_en    (test_enable),
        .test_pads (test_pads),
        .pads_q    (pads_q)
    );

    assign pad_config_clk        = pads_q[PAD_CONFIG_CLK];
    assign pad_reset_not         = pads_q[PAD_RESET_NOT];
    assign pad_config_in         = pads_q[PAD_CONFIG_IN];
    assign pad_config_load       = pads_q[PAD_CONFIG_LOAD];
    assign pad_vin_test_trig_out = pads_q[PAD_VIN_TRIG];
    assign pad_scan_in           = pads_q[PAD_SCAN_IN];
    assign pad_scan_load         = pads_q[PAD_SCAN_LOAD];

    assign seq_state    = state;
    assign seq_cur_test = cur;
    assign seq_busy     = (state == S_SELECT) || (state == S_START) ||
                          (state == S_WAIT_DONE) || (state == S_NEXT);
    assign seq_done     = (state == S_DONE);

endmodule

// File: tb/tb_ip1_test_sequencer.sv
// Bench for ip1_test_sequencer: directed runs, a responder standing in for the
// test FSMs, and an event scoreboard fed by a monitor on the start/done outputs.
`timescale 1ns/1ps
module tb_ip1_test_sequencer;

    localparam int N  = 4;
    localparam int TW = 24;
    localparam logic [6:0] PAD_DEF = 7'h0A;
    localparam logic [6:0] PAT0 = 7'h71, PAT1 = 7'h2C, PAT2 = 7'h33, PAT3 = 7'h55;

    logic          clk = 1'b0;
    logic          reset;
    logic          seq_start, seq_abort;
    logic [N-1:0]  seq_test_mask;
    logic [TW-1:0] seq_timeout_max;
    logic [N-1:0]  test_status_done;
    logic [7*N-1:0] test_pads;
    logic [N-1:0]  test_enable, test_start_re;
    logic pad_config_clk, pad_reset_not, pad_config_in, pad_config_load;
    logic pad_vin_test_trig_out, pad_scan_in, pad_scan_load;
    logic [2:0]    seq_state;
    logic [3:0]    seq_cur_test;
    logic          seq_busy, seq_done, seq_aborted, seq_timeout_err;
    logic [N-1:0]  seq_fail_mask;
    logic [6:0]    pads;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    int          resp_delay[N];
    logic [N-1:0] manual_mode, manual_level;

    assign pads = {pad_scan_load, pad_scan_in, pad_vin_test_trig_out, pad_config_load,
                   pad_config_in, pad_reset_not, pad_config_clk};

    ip1_test_sequencer #(.N_TESTS(N), .TMO_W(TW)) dut (
        .clk(clk), .reset(reset), .seq_start(seq_start), .seq_abort(seq_abort),
        .seq_test_mask(seq_test_mask), .seq_timeout_max(seq_timeout_max),
        .test_status_done(test_status_done), .test_pads(test_pads),
        .test_enable(test_enable), .test_start_re(test_start_re),
        .pad_config_clk(pad_config_clk), .pad_reset_not(pad_reset_not),
        .pad_config_in(pad_config_in), .pad_config_load(pad_config_load),
        .pad_vin_test_trig_out(pad_vin_test_trig_out), .pad_scan_in(pad_scan_in),
        .pad_scan_load(pad_scan_load), .seq_state(seq_state), .seq_cur_test(seq_cur_test),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_aborted(seq_aborted),
        .seq_timeout_err(seq_timeout_err), .seq_fail_mask(seq_fail_mask)
    );

    // ---------------- clock / time limit ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ev_start(input int i);
        logic [3:0] oh;
        oh = 4'(1 << i);
        return {4'h1, 4'(i), 4'h0, oh};
    endfunction

    function automatic logic [15:0] ev_done(input logic ab, input logic tm, input logic [3:0] fm);
        return {4'h2, 5'h0, ab, tm, 1'b0, fm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] mask);
        seq_test_mask = mask;
        seq_start = 1'b0;
        tick(1);
        seq_start = 1'b1;
    endtask

    task automatic wait_start(input int idx, input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            tick(1);
            if (test_start_re[idx]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            tick(1);
            if (seq_done) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- test FSM responder ----------------
    initial begin
        int           cnt[N];
        logic [N-1:0] run;
        test_status_done = '0;
        run = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (manual_mode[i]) begin
                    test_status_done[i] = manual_level[i];
                end else if (test_start_re[i]) begin
                    test_status_done[i] = 1'b0;
                    run[i] = 1'b1;
                    cnt[i] = 0;
                end else if (run[i]) begin
                    if (!test_enable[i]) begin
                        run[i] = 1'b0;
                    end else begin
                        cnt[i]++;
                        if (resp_delay[i] != 0 && cnt[i] >= resp_delay[i]) begin
                            test_status_done[i] = 1'b1;
                            run[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic score(input logic [15:0] got);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(got), 0);
        end else begin
            exp = exp_q.pop_front();
            check("event", 32'(got), 32'(exp));
        end
    endtask

    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (|test_start_re)
                    score({4'h1, seq_cur_test, 4'h0, test_start_re});
                if (seq_done && !prev_done)
                    score({4'h2, 5'h0, seq_aborted, seq_timeout_err, 1'b0, seq_fail_mask});
                prev_done = seq_done;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int lat, lat2;
        bit seen;
        reset = 1'b1;
        seq_start = 1'b1;
        seq_abort = 1'b0;
        seq_test_mask = '0;
        seq_timeout_max = '0;
        test_pads = {PAT3, PAT2, PAT1, PAT0};
        manual_mode = '0;
        manual_level = '0;
        for (int i = 0; i < N; i++) resp_delay[i] = 50;

        // reset values, seq_start already high at release
        tick(3);
        check("rst_state", 32'(seq_state), 0);
        check("rst_enable", 32'(test_enable), 0);
        check("rst_start_re", 32'(test_start_re), 0);
        check("rst_cur", 32'(seq_cur_test), 0);
        check("rst_status", 32'({seq_busy, seq_done, seq_aborted, seq_timeout_err}), 0);
        check("rst_fail", 32'(seq_fail_mask), 0);
        check("rst_pads", 32'(pads), 32'(PAD_DEF));
        reset = 1'b0;
        tick(5);
        check("no_edge_at_release", 32'(seq_state), 0);

        // empty mask completes three cycles after the edge
        exp_q.push_back(ev_done(1'b0, 1'b0, 4'b0000));
        launch(4'b0000);
        wait_done(10, lat);
        check("empty_done_lat", lat, 3);

        // mask 0101: test0 then test2
        exp_q.push_back(ev_start(0));
        exp_q.push_back(ev_start(2));
        exp_q.push_back(ev_done(1'b0, 1'b0, 4'b0000));
        launch(4'b0101);
        wait_start(0, 10, lat);
        check("start_lat", lat, 3);
        check("pads_before_own", 32'(pads), 32'(PAD_DEF));
        tick(1);
        check("pads_test0", 32'(pads), 32'(PAT0));
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (test_status_done[0]) begin
                seen = 1;
                break;
            end
        end
        wait_start(2, 10, lat2);
        check("done_to_start_lat", seen ? 1 + lat2 : -1, 4);
        tick(1);
        check("pads_test2", 32'(pads), 32'(PAT2));
        wait_done(100, lat);
        check("m0101_done", 32'(seq_done), 1);
        check("m0101_fail", 32'(seq_fail_mask), 0);
        check("pads_default_after", 32'(pads), 32'(PAD_DEF));

        // stale done on test1 is ignored
        manual_mode[1] = 1'b1;
        manual_level[1] = 1'b1;
        tick(5);
        exp_q.push_back(ev_start(1));
        exp_q.push_back(ev_done(1'b0, 1'b0, 4'b0000));
        launch(4'b0010);
        wait_start(1, 10, lat);
        check("stale_start_lat", lat, 3);
        tick(20);
        check("stale_still_wait", 32'(seq_state), 3);
        manual_level[1] = 1'b0;
        tick(3);
        check("stale_fall_wait", 32'(seq_state), 3);
        manual_level[1] = 1'b1;
        wait_done(20, lat);
        check("fresh_edge_done_lat", lat, 4);

        // test3 never completes
        manual_mode[1] = 1'b0;
        resp_delay[3] = 0;
        seq_timeout_max = 100;
        exp_q.push_back(ev_start(3));
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
        exp_q.push_back(ev_done(1'b0, 1'b1, 4'b1000));
`else
        exp_q.push_back(ev_done(1'b1, 1'b0, 4'b0000));
`endif
        launch(4'b1000);
        wait_start(3, 10, lat);
        check("tmo_start_lat", lat, 3);
        tick(90);
        check("tmo_wait_state", 32'(seq_state), 3);
        check("tmo_not_yet", 32'(seq_timeout_err), 0);
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
        wait_done(40, lat);
        check("tmo_done_lat", lat, 14);
        check("tmo_fail_mask", 32'(seq_fail_mask), 32'(4'b1000));
        check("tmo_err", 32'(seq_timeout_err), 1);
`else
        tick(300);
        check("no_wdog_state", 32'(seq_state), 3);
        check("no_wdog_busy", 32'(seq_busy), 1);
        seq_abort = 1'b1;
        tick(1);
        seq_abort = 1'b0;
        check("no_wdog_abort_state", 32'(seq_state), 5);
`endif

        // abort on test1 in the same cycle its completion is seen
        seq_timeout_max = 1000;
        manual_mode[1] = 1'b1;
        manual_level[1] = 1'b0;
        tick(3);
        exp_q.push_back(ev_start(1));
        exp_q.push_back(ev_done(1'b1, 1'b0, 4'b0000));
        launch(4'b0110);
        wait_start(1, 10, lat);
        check("abort_start_lat", lat, 3);
        tick(10);
        manual_level[1] = 1'b1;
        tick(1);
        seq_abort = 1'b1;
        #2;
        check("abort_enable_drop", 32'(test_enable), 0);
        tick(1);
        check("abort_state_done", 32'(seq_state), 5);
        check("abort_flags", 32'({seq_aborted, seq_busy, seq_done}), 32'(3'b101));
        seq_abort = 1'b0;
        tick(60);
        check("abort_skip_rest", 32'(test_enable), 0);

        // asynchronous reset mid-sequence, then a full rerun
        manual_mode[1] = 1'b0;
        exp_q.push_back(ev_start(0));
        launch(4'b0011);
        wait_start(0, 10, lat);
        tick(10);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(seq_state), 0);
        check("mid_rst_enable", 32'(test_enable), 0);
        check("mid_rst_busy", 32'(seq_busy), 0);
        check("mid_rst_pads", 32'(pads), 32'(PAD_DEF));
        tick(2);
        reset = 1'b0;
        tick(3);
        check("post_rst_idle", 32'(seq_state), 0);
        exp_q.push_back(ev_start(0));
        exp_q.push_back(ev_start(1));
        exp_q.push_back(ev_done(1'b0, 1'b0, 4'b0000));
        launch(4'b0011);
        wait_done(300, lat);
        check("rerun_done", 32'(seq_done), 1);

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
